// File: rtl/apb_master_bridge.sv
// APB requester: one command at a time through SETUP/ACCESS, with a range check
// on the word address and an ACCESS timeout so a stuck slave cannot hang the requester.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_LIMIT     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  select,
    output logic                  enable,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  ready,
    input  logic                  slave_error,
    input  logic [DATA_WIDTH-1:0] read_data
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] LIMIT     = ADDR_WIDTH'(ADDR_LIMIT);
    localparam logic [7:0]            WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state, next_state;
    logic [7:0]            wait_count, wait_count_d;
    logic                  accept, in_range, timed_out;
    logic                  select_d, enable_d, write_en_d, cmd_ready_d;
    logic                  rsp_valid_d, rsp_error_d;
    logic [ADDR_WIDTH-1:0] address_d;
    logic [DATA_WIDTH-1:0] write_data_d, rsp_rdata_d;

    // cmd_ready is registered, so it is only ever high while in IDLE
    assign accept    = cmd_valid && cmd_ready;
    assign in_range  = cmd_address < LIMIT;
    assign timed_out = !ready && (wait_count == WAIT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_count <= '0;
            select     <= 1'b0;
            enable     <= 1'b0;
            write_en   <= 1'b0;
            address    <= '0;
            write_data <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_error  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state      <= next_state;
            wait_count <= wait_count_d;
            select     <= select_d;
            enable     <= enable_d;
            write_en   <= write_en_d;
            address    <= address_d;
            write_data <= write_data_d;
            cmd_ready  <= cmd_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_error  <= rsp_error_d;
            rsp_rdata  <= rsp_rdata_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = in_range ? SETUP : RESP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (ready || timed_out) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        select_d     = (next_state == SETUP) || (next_state == ACCESS);
        enable_d     = (next_state == ACCESS);
        cmd_ready_d  = (next_state == IDLE);
        rsp_valid_d  = (next_state == RESP);
        write_en_d   = write_en;
        address_d    = address;
        write_data_d = write_data;
        rsp_error_d  = rsp_error;
        rsp_rdata_d  = rsp_rdata;
        wait_count_d = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        write_en_d   = cmd_write;
                        address_d    = cmd_address;
                        write_data_d = cmd_write ? cmd_wdata : '0;
                    end else begin
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (ready) begin
                    rsp_error_d = slave_error;
                    rsp_rdata_d = write_en ? '0 : read_data;
                end else if (timed_out) begin
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_count_d = wait_count + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a 32-word APB slave stub and a
// response scoreboard filled at command accept and drained at response handshake.
module tb_apb_master_bridge;

    logic        clock, reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_address, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic        select, enable, write_en;
    logic [31:0] address, write_data;
    logic        ready, slave_error;
    logic [31:0] read_data;

    apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_LIMIT(32), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .select(select), .enable(enable), .write_en(write_en),
        .address(address), .write_data(write_data),
        .ready(ready), .slave_error(slave_error), .read_data(read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // slave stub: zero wait states unless stalled
    logic [31:0] slave_mem [32];
    logic        stall, inj_err;
    assign ready       = select && enable && !stall;
    assign slave_error = ready && inj_err;
    assign read_data   = (select && enable && !write_en) ? slave_mem[address[4:0]] : 32'h0;
    always @(posedge clock) if (select && enable && ready && write_en) slave_mem[address[4:0]] <= write_data;

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t        sb[$];
    logic [31:0] mem_model [32];
    int          checks = 0, errors = 0;
    int          cyc = 0, acc_cyc = 0, en_cnt = 0;
    logic        sel_seen = 0, rsp_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clock) cyc++;

    // monitors: accept -> push expectation, handshake -> pop/compare, bus rules
    always @(negedge clock) begin
        exp_t e, g;
        if (select) sel_seen = 1'b1;
        if (enable) en_cnt++;
        if (rsp_valid) rsp_seen = 1'b1;
        if (enable) chk("enable_without_select", select, 1);
        if (select && !write_en) chk("read_write_data_zero", write_data, 0);
        if (reset && cmd_valid && cmd_ready) begin
            acc_cyc = cyc;
            e.rdata = 32'h0;
            e.err   = 1'b0;
            if (cmd_address >= 32) e.err = 1'b1;
            else if (stall) e.err = 1'b1;
            else if (cmd_write) mem_model[cmd_address[4:0]] = cmd_wdata;
            else begin
                e.rdata = mem_model[cmd_address[4:0]];
                e.err   = inj_err;
            end
            sb.push_back(e);
        end
        if (reset && rsp_valid && rsp_ready) begin
            chk("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                g = sb.pop_front();
                chk("sb_rdata", rsp_rdata, g.rdata);
                chk("sb_error", rsp_error, g.err);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // returns one cycle after the accepting cycle
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_wdata = d;
        for (n = 0; n < 50; n++) begin
            @(negedge clock);
            if (cmd_ready) break;
        end
        if (n == 50) chk("accept_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n;
        lat = -1;
        for (n = 0; n < 100; n++) begin
            @(negedge clock);
            if (rsp_valid) break;
        end
        if (n == 100) chk("rsp_timeout", 0, 1);
        else lat = cyc - acc_cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, c1, c2, gap;
        logic seen;
        for (int i = 0; i < 32; i++) begin slave_mem[i] = 32'h0; mem_model[i] = 32'h0; end
        reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_address = 0; cmd_wdata = 0;
        rsp_ready = 1'b1; stall = 0; inj_err = 0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ctrl", {select, enable, write_en, cmd_ready, rsp_valid, rsp_error}, 0);
        chk("reset_data", {address, write_data}, 0);
        chk("reset_rdata", rsp_rdata, 0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("ready_before_edge", cmd_ready, 0);
        @(negedge clock);
        chk("ready_after_release", cmd_ready, 1);
        tick();

        // 1: write with zero wait states
        send(1, 5, 32'hDEADBEEF);
        @(negedge clock);
        chk("t1_setup_sel_en", {select, enable}, 2'b10);
        chk("t1_setup_fields", {write_en, address, write_data}, {1'b1, 32'd5, 32'hDEADBEEF});
        @(negedge clock);
        chk("t1_access_sel_en", {select, enable}, 2'b11);
        wait_rsp(lat);
        chk("t1_latency", lat, 3);
        chk("t1_rsp", {rsp_error, rsp_rdata}, 0);
        tick();

        // 2: read back, bus idle during RESP
        send(0, 5, 32'hFFFF0000);
        wait_rsp(lat);
        chk("t2_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t2_resp_bus_idle", {select, enable}, 0);
        tick();

        // 3: back-to-back writes with cmd_valid held
        cmd_valid = 1; cmd_write = 1; cmd_address = 0; cmd_wdata = 32'hA5A5_0001;
        for (c1 = 0; c1 < 20; c1++) begin @(negedge clock); if (cmd_ready) break; end
        c1 = cyc;
        tick();
        cmd_address = 31; cmd_wdata = 32'h5A5A_001F;
        seen = 0; gap = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (select) seen = 1;
            else if (seen) gap++;
            if (cmd_ready) break;
        end
        c2 = cyc;
        chk("t3_accept_spacing", c2 - c1, 4);
        chk("t3_select_gap", gap >= 1, 1);
        tick();
        cmd_valid = 0;
        wait_rsp(lat);
        tick();
        send(0, 0, 0);
        wait_rsp(lat);
        tick();
        send(0, 31, 0);
        wait_rsp(lat);
        chk("t3_rdata31", rsp_rdata, 32'h5A5A_001F);
        tick();

        // 4: out-of-range commands
        sel_seen = 0;
        send(0, 32, 0);
        wait_rsp(lat);
        chk("t4_lat_32", lat, 1);
        chk("t4_rsp_32", {rsp_error, rsp_rdata}, {1'b1, 32'h0});
        tick();
        send(1, 32'hFFFFFFFF, 32'h1234);
        wait_rsp(lat);
        chk("t4_lat_max", lat, 1);
        chk("t4_rsp_max", {rsp_error, rsp_rdata}, {1'b1, 32'h0});
        chk("t4_no_select", sel_seen, 0);
        tick();

        // 5: stuck slave times out, then normal traffic resumes
        stall = 1; en_cnt = 0;
        send(0, 7, 0);
        wait_rsp(lat);
        chk("t5_enable_cycles", en_cnt, 16);
        chk("t5_rsp", {rsp_error, rsp_rdata}, {1'b1, 32'h0});
        tick();
        stall = 0;
        send(1, 7, 32'h12345678);
        wait_rsp(lat);
        chk("t5_next_lat", lat, 3);
        tick();
        inj_err = 1;
        send(0, 7, 0);
        wait_rsp(lat);
        chk("t5_slave_err_rsp", {rsp_error, rsp_rdata}, {1'b1, 32'h12345678});
        tick();
        inj_err = 0;

        // 6: held response, then reset during ACCESS
        rsp_ready = 0;
        send(0, 31, 0);
        wait_rsp(lat);
        for (int i = 0; i < 10; i++) begin
            chk("t6_hold_ctrl", {rsp_valid, cmd_ready, rsp_error}, 3'b100);
            chk("t6_hold_rdata", rsp_rdata, 32'h5A5A_001F);
            @(negedge clock);
        end
        tick();
        rsp_ready = 1;
        tick();
        stall = 1;
        send(0, 9, 0);
        @(negedge clock);
        @(negedge clock);
        chk("t6_in_access", {select, enable}, 2'b11);
        #1 reset = 0;
        #1;
        chk("t6_reset_ctrl", {select, enable, write_en, cmd_ready, rsp_valid, rsp_error}, 0);
        chk("t6_reset_data", {address, write_data, rsp_rdata}, 0);
        sb.delete();
        repeat (2) tick();
        stall = 0;
        reset = 1;
        rsp_seen = 0;
        repeat (20) tick();
        chk("t6_no_rsp_after_reset", rsp_seen, 0);
        send(0, 0, 0);
        wait_rsp(lat);
        chk("t6_post_reset_read", rsp_rdata, 32'hA5A5_0001);
        tick();
        repeat (2) tick();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
